rb_frame_scheduler: RTL and testbench

- Frame-level sequencer that sits above the row-buffer control FSM.
- Runs a programmed number of frames back to back through the BRAM row-buffer datapath. For each frame it:
  - waits for the upstream frame source,
  - releases the controller's start hold,
  - watches for completion under a watchdog timeout,
  - hands a per-frame result token to the downstream consumer with a valid/ready handshake before it arms the next frame.

---
 rtl/rb_frame_scheduler.sv | 139 +++++++++++++
 tb/tb_rb_frame_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rb_frame_scheduler.sv
// rb_frame_scheduler: frame-level sequencer above the row-buffer controller.
// Runs a job of N frames; each frame waits for the upstream source, releases
// the controller's start hold, supervises completion with a watchdog and then
// hands a result token downstream over a valid/ready handshake.
module rb_frame_scheduler #(
  parameter int FRAME_W = 8,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               abort,
  input  logic [FRAME_W-1:0] cfg_num_frames,
  input  logic               frame_req,
  output logic               frame_ack,
  output logic               rb_start,
  input  logic               rb_complete,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [FRAME_W-1:0] res_frame,
  output logic               busy,
  output logic               done,
  output logic               err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_FINISH,
    S_ERR
  } state_t;

  // Last watchdog value a frame may spend in RUN before it is declared hung.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [FRAME_W-1:0] r_num;
  logic [FRAME_W-1:0] r_frame_idx;
  logic [TO_W-1:0]    r_wd_cnt;
  logic               r_frame_ack;
  logic               r_rb_start;
  logic               r_res_valid;
  logic [FRAME_W-1:0] r_res_frame;
  logic               r_busy;
  logic               r_done;
  logic               r_err_timeout;

  logic               w_go_ok;
  logic               w_hs;
  logic               w_last;
  logic               w_wd_exp;

  assign w_go_ok  = go && ((r_state == S_IDLE) || (r_state == S_ERR));
  assign w_hs     = r_res_valid && res_ready;
  assign w_last   = (r_frame_idx == (r_num - 1'b1));
  assign w_wd_exp = (r_wd_cnt == WD_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    // NOTE: default assigned first so no branch leaves it unassigned, which
    // would otherwise infer a latch.
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (go) w_state_nxt = S_ARM;
        S_ARM:    if (frame_req) w_state_nxt = S_RUN;
        S_RUN: begin
          if (rb_complete)   w_state_nxt = S_DRAIN;
          else if (w_wd_exp) w_state_nxt = S_ERR;
        end
        S_DRAIN:  if (w_hs) w_state_nxt = w_last ? S_FINISH : S_ARM;
        S_FINISH: w_state_nxt = S_IDLE;
        S_ERR:    if (go) w_state_nxt = S_ARM;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered Moore outputs decoded from the next state, plus job counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_ack   <= 1'b0;
      r_rb_start    <= 1'b1;
      r_res_valid   <= 1'b0;
      r_res_frame   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_num         <= '0;
      r_frame_idx   <= '0;
      r_wd_cnt      <= '0;
    end else begin
      r_rb_start  <= (w_state_nxt != S_RUN);
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERR);
      r_res_valid <= (w_state_nxt == S_DRAIN);
      r_done      <= (w_state_nxt == S_FINISH);
      r_frame_ack <= (r_state == S_ARM) && (w_state_nxt == S_RUN);
      if (!abort) begin
        // A zero frame count still runs one frame.
        if (w_go_ok) begin
          r_num         <= (cfg_num_frames == '0) ? FRAME_W'(1) : cfg_num_frames;
          r_frame_idx   <= '0;
          r_err_timeout <= 1'b0;
        end
        if ((r_state == S_ARM) && frame_req) r_wd_cnt <= '0;
        if (r_state == S_RUN) begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          // Completion beats a watchdog expiry on the same cycle.
          if (rb_complete)   r_res_frame   <= r_frame_idx;
          else if (w_wd_exp) r_err_timeout <= 1'b1;
        end
        if ((r_state == S_DRAIN) && w_hs && !w_last) r_frame_idx <= r_frame_idx + 1'b1;
      end
    end
  end

  assign frame_ack   = r_frame_ack;
  assign rb_start    = r_rb_start;
  assign res_valid   = r_res_valid;
  assign res_frame   = r_res_frame;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_rb_frame_scheduler.sv
// Testbench for rb_frame_scheduler. Two instances share one stimulus stream:
// a long-watchdog instance for normal jobs and a TIMEOUT=20 instance for
// watchdog scenarios; sel picks which one is observed.
module tb_rb_frame_scheduler;
  localparam int FW      = 8;
  localparam int TO_MAIN = 64;
  localparam int TO_WD   = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go;
  logic          abort;
  logic [FW-1:0] cfg_num_frames;
  logic          frame_req;
  logic          rb_complete;
  logic          res_ready;
  logic          sel;

  logic          a_frame_ack, a_rb_start, a_res_valid, a_busy, a_done, a_err;
  logic [FW-1:0] a_res_frame;
  logic          b_frame_ack, b_rb_start, b_res_valid, b_busy, b_done, b_err;
  logic [FW-1:0] b_res_frame;

  logic          c_frame_ack, c_rb_start, c_res_valid, c_busy, c_done, c_err;
  logic [FW-1:0] c_res_frame;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rb_frame_scheduler #(.FRAME_W(FW), .TO_W(16), .TIMEOUT(TO_MAIN)) u_dut_main (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .cfg_num_frames(cfg_num_frames),
    .frame_req(frame_req), .frame_ack(a_frame_ack), .rb_start(a_rb_start),
    .rb_complete(rb_complete), .res_valid(a_res_valid), .res_ready(res_ready),
    .res_frame(a_res_frame), .busy(a_busy), .done(a_done), .err_timeout(a_err)
  );

  rb_frame_scheduler #(.FRAME_W(FW), .TO_W(16), .TIMEOUT(TO_WD)) u_dut_wd (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .cfg_num_frames(cfg_num_frames),
    .frame_req(frame_req), .frame_ack(b_frame_ack), .rb_start(b_rb_start),
    .rb_complete(rb_complete), .res_valid(b_res_valid), .res_ready(res_ready),
    .res_frame(b_res_frame), .busy(b_busy), .done(b_done), .err_timeout(b_err)
  );

  assign c_frame_ack = sel ? b_frame_ack : a_frame_ack;
  assign c_rb_start  = sel ? b_rb_start  : a_rb_start;
  assign c_res_valid = sel ? b_res_valid : a_res_valid;
  assign c_res_frame = sel ? b_res_frame : a_res_frame;
  assign c_busy      = sel ? b_busy      : a_busy;
  assign c_done      = sel ? b_done      : a_done;
  assign c_err       = sel ? b_err       : a_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock; outputs are then observed and inputs driven at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag, input int exp_err);
    check({tag, "_busy"},  32'(c_busy), 0);
    check({tag, "_start"}, 32'(c_rb_start), 1);
    check({tag, "_valid"}, 32'(c_res_valid), 0);
    check({tag, "_ack"},   32'(c_frame_ack), 0);
    check({tag, "_done"},  32'(c_done), 0);
    check({tag, "_err"},   32'(c_err), 32'(exp_err));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; frame_req = 1'b0;
    rb_complete = 1'b0; res_ready = 1'b0; cfg_num_frames = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("rst", 0);
    check("rst_frame", 32'(c_res_frame), 0);
    rst_n = 1'b1;
    step();
    check_idle("post_rst", 0);
  endtask

  task automatic start_job(input logic [FW-1:0] cfg);
    go = 1'b1;
    cfg_num_frames = cfg;
    step();
    go = 1'b0;
    cfg_num_frames = FW'($urandom);
    check("job_err_clr", 32'(c_err), 0);
    check("job_done", 32'(c_done), 0);
    check("job_busy", 32'(c_busy), 1);
  endtask

  // Expected behaviour of one frame: d_req ARM cycles without frame_req,
  // completion on RUN cycle lat (0 = first RUN cycle), rdy_wait cycles of
  // back-pressure. A frame with lat beyond TIMEOUT-1 ends in ERR after
  // exactly TIMEOUT RUN cycles.
  task automatic run_frame(input int idx, input bit last, input int d_req, input int lat,
                           input int rdy_wait, input bit hold, output bit timed_out);
    int to;
    to = sel ? TO_WD : TO_MAIN;
    timed_out = 1'b0;
    for (int j = 0; j <= d_req; j++) begin
      check("arm_ack",   32'(c_frame_ack), 0);
      check("arm_start", 32'(c_rb_start), 1);
      check("arm_valid", 32'(c_res_valid), 0);
      check("arm_busy",  32'(c_busy), 1);
      frame_req = (j == d_req);
      go = (j < d_req) ? 1'($urandom_range(0, 1)) : 1'b0;
      cfg_num_frames = FW'($urandom);
      step();
    end
    go = 1'b0;
    for (int c = 0; c < to; c++) begin
      check("run_ack",   32'(c_frame_ack), (c == 0) ? 1 : 0);
      check("run_start", 32'(c_rb_start), 0);
      check("run_busy",  32'(c_busy), 1);
      check("run_valid", 32'(c_res_valid), 0);
      check("run_err",   32'(c_err), 0);
      frame_req = hold | 1'($urandom_range(0, 1));
      if (c == lat) begin
        rb_complete = 1'b1;
        step();
        rb_complete = 1'b0;
        break;
      end
      rb_complete = 1'b0;
      if (c == to - 1) begin
        step();
        timed_out = 1'b1;
        break;
      end
      step();
    end
    if (timed_out) begin
      check("tmo_err",   32'(c_err), 1);
      check("tmo_start", 32'(c_rb_start), 1);
      check("tmo_busy",  32'(c_busy), 0);
      check("tmo_valid", 32'(c_res_valid), 0);
      return;
    end
    for (int r = 0; r <= rdy_wait; r++) begin
      check("drn_valid", 32'(c_res_valid), 1);
      check("drn_frame", 32'(c_res_frame), 32'(idx % 256));
      check("drn_start", 32'(c_rb_start), 1);
      check("drn_ack",   32'(c_frame_ack), 0);
      check("drn_done",  32'(c_done), 0);
      check("drn_err",   32'(c_err), 0);
      res_ready = (r == rdy_wait);
      frame_req = hold | 1'($urandom_range(0, 1));
      go = (r < rdy_wait) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    res_ready = 1'b0;
    go = 1'b0;
    if (last) begin
      check("fin_done",  32'(c_done), 1);
      check("fin_valid", 32'(c_res_valid), 0);
      check("fin_busy",  32'(c_busy), 1);
      frame_req = hold;
      step();
      check_idle("end", 0);
    end else begin
      check("next_valid", 32'(c_res_valid), 0);
    end
  endtask

  task automatic run_job(input int cfg, input int lat, input int rdy, input bit hold, input bit rnd);
    int n, to, d, l, r;
    bit tmo;
    to = sel ? TO_WD : TO_MAIN;
    start_job(FW'(cfg));
    n = (cfg == 0) ? 1 : cfg;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        d = $urandom_range(0, 3);
        case ($urandom_range(0, 9))
          0:       l = to - 1;
          1:       l = to;
          2:       l = to + 10;
          default: l = $urandom_range(0, (to < 45) ? to + 3 : 45);
        endcase
        r = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3);
      end else begin
        d = 0; l = lat; r = rdy;
      end
      run_frame(i, (i == n - 1), d, l, r, hold, tmo);
      if (tmo) break;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: bench exceeded its time budget");
    $fatal(1, "bench time budget exceeded");
  end

  initial begin
    bit tmo;
    sel = 1'b0;
    apply_reset();

    // Basic job: 3 frames, frame_req held, completion 40 cycles after rb_start falls.
    run_job(3, 40, 0, 1'b1, 1'b0);
    // Back-pressure: res_ready low for 7 cycles after res_valid rises.
    run_job(2, 12, 7, 1'b1, 1'b0);
    // Zero frames runs exactly one frame.
    run_job(0, 5, 0, 1'b0, 1'b0);
    // Randomised jobs, some of which hit the watchdog.
    repeat (12) run_job($urandom_range(0, 5), 0, 0, 1'b0, 1'b1);

    // Abort on RUN cycle 10.
    start_job(3);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    repeat (10) begin
      check("pre_abort_start", 32'(c_rb_start), 0);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("abort", 0);
    rb_complete = 1'b1; res_ready = 1'b1; frame_req = 1'b1;
    repeat (4) begin
      step();
      check_idle("post_abort", 0);
    end
    rb_complete = 1'b0; res_ready = 1'b0; frame_req = 1'b0;

    // Asynchronous reset while frame 1 sits in DRAIN.
    start_job(2);
    run_frame(0, 1'b0, 0, 3, 0, 1'b0, tmo);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    rb_complete = 1'b1;
    step();
    rb_complete = 1'b0;
    check("pre_rst_valid", 32'(c_res_valid), 1);
    check("pre_rst_frame", 32'(c_res_frame), 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst", 0);
    check("async_rst_frame", 32'(c_res_frame), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_idle("after_async", 0);

    // Short-watchdog instance.
    sel = 1'b1;
    apply_reset();
    start_job(2);
    run_frame(0, 1'b0, 1, 1000, 0, 1'b0, tmo);
    rb_complete = 1'b1;
    repeat (3) begin
      step();
      check_idle("err_hold", 1);
    end
    rb_complete = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("err_abort", 1);
    // A new go clears the error and restarts from frame 0.
    run_job(2, 5, 1, 1'b0, 1'b0);
    // Completion on the very cycle the watchdog expires wins.
    run_job(1, TO_WD - 1, 0, 1'b0, 1'b0);
    // One cycle later the watchdog fires.
    run_job(1, TO_WD, 0, 1'b0, 1'b0);
    repeat (6) run_job($urandom_range(0, 4), 0, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
